// File: rtl/oled_i2c_pkg.sv
// Shared constants and FSM encoding for the OLED I2C receive target.
package oled_i2c_pkg;

   // 7-bit address of the SSD1306 0.91" module
   localparam logic [6:0] OLED_I2C_ADDR = 7'h3C;

   // Control bytes: bit7 = Co (1 = single byte follows), bit6 = D/C#
   localparam logic [7:0] CTRL_CMD_STREAM  = 8'h00;
   localparam logic [7:0] CTRL_DATA_STREAM = 8'h40;
   localparam logic [7:0] CTRL_CMD_SINGLE  = 8'h80;
   localparam logic [7:0] CTRL_DATA_SINGLE = 8'hC0;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      CTRL,
      CTRL_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Synchronises SCL/SDA into the clk domain and flags edges and bus conditions.
module i2c_bus_cond_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync_reg;
   logic [SYNC_STAGES-1:0] sda_sync_reg;
   logic                   scl_d_reg;
   logic                   sda_d_reg;
   logic                   scl_s;

   // Synchroniser chains plus one delay stage; idle bus level (1) after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_d_reg    <= 1'b1;
         sda_d_reg    <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
         scl_d_reg    <= scl_s;
         sda_d_reg    <= sda_s;
      end
   end

   assign scl_s = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s = sda_sync_reg[SYNC_STAGES-1];

   assign scl_rise = scl_s & ~scl_d_reg;
   assign scl_fall = ~scl_s & scl_d_reg;

   // SDA edges only count as bus conditions while SCL is steadily high,
   // so a condition and an SCL edge can never fire in the same cycle
   assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
   assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/oled_i2c_rx_slave.sv
// Write-only I2C target modelling the SSD1306 interface: ACKs its address,
// decodes control bytes and strobes out command/data payload bytes.
module oled_i2c_rx_slave
   import oled_i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = OLED_I2C_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        CLOCK,
   input  logic        RST_n,
   input  logic        OLED_SCL,
   inout  wire         OLED_SDA,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        rx_dc,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy,
   output logic [15:0] byte_cnt
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_cond_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cond (
      .clk       (CLOCK),
      .rst_n     (RST_n),
      .scl_in    (OLED_SCL),
      .sda_in    (OLED_SDA),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_state_t  state_reg, state_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [6:0]  shift_reg, shift_next;
   logic        co_reg, co_next;
   logic        dc_reg, dc_next;
   logic        ack_low_reg, ack_low_next;
   logic        busy_reg, busy_next;
   logic [15:0] byte_cnt_reg, byte_cnt_next;
   logic [7:0]  rx_byte_reg, rx_byte_next;
   logic        rx_dc_reg, rx_dc_next;
   logic        rx_valid_reg, rx_valid_next;
   logic        frame_start_reg, frame_start_next;
   logic        frame_done_reg, frame_done_next;
   logic [7:0]  byte_in;

   // Full byte as it stands once the current SDA bit is shifted in
   assign byte_in = {shift_reg, sda_s};

   // State and output registers; reset releases SDA immediately
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         co_reg          <= 1'b0;
         dc_reg          <= 1'b0;
         ack_low_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         byte_cnt_reg    <= '0;
         rx_byte_reg     <= '0;
         rx_dc_reg       <= 1'b0;
         rx_valid_reg    <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         co_reg          <= co_next;
         dc_reg          <= dc_next;
         ack_low_reg     <= ack_low_next;
         busy_reg        <= busy_next;
         byte_cnt_reg    <= byte_cnt_next;
         rx_byte_reg     <= rx_byte_next;
         rx_dc_reg       <= rx_dc_next;
         rx_valid_reg    <= rx_valid_next;
         frame_start_reg <= frame_start_next;
         frame_done_reg  <= frame_done_next;
      end
   end

   // Next-state decode: bus conditions first, then per-state bit handling
   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      co_next          = co_reg;
      dc_next          = dc_reg;
      ack_low_next     = ack_low_reg;
      busy_next        = busy_reg;
      byte_cnt_next    = byte_cnt_reg;
      rx_byte_next     = rx_byte_reg;
      rx_dc_next       = rx_dc_reg;
      rx_valid_next    = 1'b0;
      frame_start_next = 1'b0;
      frame_done_next  = 1'b0;

      if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = '0;
         ack_low_next = 1'b0;
         busy_next    = 1'b0;
      end else if (stop_det) begin
         state_next      = IDLE;
         bit_cnt_next    = '0;
         ack_low_next    = 1'b0;
         busy_next       = 1'b0;
         frame_done_next = busy_reg;
      end else begin
         case (state_reg)
            ADDR, CTRL, DATA: begin
               if (scl_rise) begin
                  shift_next   = byte_in[6:0];
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     if (state_reg == ADDR) begin
                        if (byte_in == {SLAVE_ADDR, 1'b0}) begin
                           state_next       = ADDR_ACK;
                           frame_start_next = 1'b1;
                           busy_next        = 1'b1;
                           byte_cnt_next    = '0;
                        end else begin
                           state_next = IGNORE;
                        end
                     end else if (state_reg == CTRL) begin
                        co_next    = byte_in[7];
                        dc_next    = byte_in[6];
                        state_next = CTRL_ACK;
                     end else begin
                        rx_valid_next = 1'b1;
                        rx_byte_next  = byte_in;
                        rx_dc_next    = dc_reg;
                        if (byte_cnt_reg != 16'hFFFF)
                           byte_cnt_next = byte_cnt_reg + 16'd1;
                        state_next = DATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, CTRL_ACK, DATA_ACK: begin
               // First falling edge pulls SDA low, the 9th clock's fall releases it
               if (scl_fall) begin
                  if (!ack_low_reg) begin
                     ack_low_next = 1'b1;
                  end else begin
                     ack_low_next = 1'b0;
                     bit_cnt_next = '0;
                     if (state_reg == ADDR_ACK)
                        state_next = CTRL;
                     else if (state_reg == CTRL_ACK)
                        state_next = DATA;
                     else
                        state_next = co_reg ? CTRL : DATA;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign OLED_SDA    = ack_low_reg ? 1'b0 : 1'bz;
   assign rx_byte     = rx_byte_reg;
   assign rx_valid    = rx_valid_reg;
   assign rx_dc       = rx_dc_reg;
   assign frame_start = frame_start_reg;
   assign frame_done  = frame_done_reg;
   assign busy        = busy_reg;
   assign byte_cnt    = byte_cnt_reg;

endmodule

// File: tb/tb_oled_i2c_rx_slave.sv
// Bench master plus byte-level reference model for oled_i2c_rx_slave.
module tb_oled_i2c_rx_slave;
   import oled_i2c_pkg::*;

   localparam int SYNC = 2;

   typedef struct {
      logic [7:0]  b;
      logic        dc;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        m_low = 1'b0;
   wire         sda_bus;
   logic [7:0]  rx_byte;
   logic        rx_valid, rx_dc, frame_start, frame_done, busy;
   logic [15:0] byte_cnt;

   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   oled_i2c_rx_slave #(
      .SLAVE_ADDR  (7'h3C),
      .SYNC_STAGES (SYNC)
   ) dut (
      .CLOCK       (clk),
      .RST_n       (rst_n),
      .OLED_SCL    (scl),
      .OLED_SDA    (sda_bus),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .rx_dc       (rx_dc),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .busy        (busy),
      .byte_cnt    (byte_cnt)
   );

   always #20 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   lsb_cyc = 0;
   int   q = 10;
   int   exp_cnt = 0;
   int   fs_pend = 0;
   int   fd_pend = 0;
   int   drive_viol = 0;
   int   busy_viol = 0;
   bit   quiet_win = 1'b0;
   bit   bus_idle = 1'b1;
   exp_t exp_q[$];
   logic [8:0] obs_q[$];
   logic [7:0] frm [8];
   logic [7:0] ctrl_tab [4];
   exp_t cur_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Compare process: every strobe/pulse is checked against the model
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               cur_e = exp_q.pop_front();
               chk("rx_byte", 32'(rx_byte), 32'(cur_e.b));
               chk("rx_dc", 32'(rx_dc), 32'(cur_e.dc));
               chk("byte_cnt_at_strobe", 32'(byte_cnt), 32'(cur_e.cnt));
               chk("rx_latency", 32'(cyc - lsb_cyc), 32'(SYNC + 1));
            end
            obs_q.push_back({rx_dc, rx_byte});
            $display("[TB] rx byte=%02h dc=%0d cnt=%0d", rx_byte, rx_dc, byte_cnt);
         end
         if (frame_start) begin
            chk("frame_start_expected", 32'(fs_pend > 0), 32'd1);
            if (fs_pend > 0) fs_pend--;
            chk("byte_cnt_cleared", 32'(byte_cnt), 32'd0);
         end
         if (frame_done) begin
            chk("frame_done_expected", 32'(fd_pend > 0), 32'd1);
            if (fd_pend > 0) fd_pend--;
            chk("busy_falls_with_done", 32'(busy), 32'd0);
         end
      end
   end

   // Watch for any target drive or busy while no frame is addressed to it
   always @(posedge clk) begin
      if (quiet_win) begin
         if (sda_bus === 1'b0 && !m_low) drive_viol <= drive_viol + 1;
         if (busy) busy_viol <= busy_viol + 1;
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put_bit(input logic b, input bit is_lsb);
      m_low = ~b;
      cyc_wait(q);
      scl = 1'b1;
      if (is_lsb) lsb_cyc = cyc;
      cyc_wait(2 * q);
      scl = 1'b0;
      cyc_wait(q);
   endtask

   task automatic put_byte(input logic [7:0] b, input bit exp_ack);
      logic ack;
      for (int i = 7; i >= 0; i--) put_bit(b[i], i == 0);
      m_low = 1'b0;
      cyc_wait(q);
      scl = 1'b1;
      cyc_wait(q);
      ack = (sda_bus === 1'b0);
      chk("ack", 32'(ack), 32'(exp_ack));
      $display("[TB] byte %02h ack=%0d", b, ack);
      cyc_wait(q);
      scl = 1'b0;
      cyc_wait(q);
   endtask

   task automatic bus_start();
      if (bus_idle) begin
         m_low = 1'b1;
         cyc_wait(q);
         scl = 1'b0;
         cyc_wait(q);
      end else begin
         m_low = 1'b0;
         cyc_wait(q);
         scl = 1'b1;
         cyc_wait(q);
         m_low = 1'b1;
         cyc_wait(q);
         scl = 1'b0;
         cyc_wait(q);
         chk("busy_after_rep_start", 32'(busy), 32'd0);
      end
   endtask

   task automatic bus_stop();
      m_low = 1'b1;
      cyc_wait(q);
      scl = 1'b1;
      cyc_wait(q);
      m_low = 1'b0;
      cyc_wait(q);
   endtask

   // Byte-level model: control byte sets Co/DC, payload follows per Co
   task automatic run_frame(input int nb, input int part, input bit end_stop);
      bit   matched, in_ctrl, co, dc;
      exp_t e;
      matched = (frm[0] == 8'h78);
      in_ctrl = 1'b1;
      co = 1'b0;
      dc = 1'b0;
      if (matched) begin
         fs_pend++;
         exp_cnt = 0;
         for (int i = 1; i < nb; i++) begin
            if (in_ctrl) begin
               co = frm[i][7];
               dc = frm[i][6];
               in_ctrl = 1'b0;
            end else begin
               if (exp_cnt < 65535) exp_cnt++;
               e.b = frm[i];
               e.dc = dc;
               e.cnt = 16'(exp_cnt);
               exp_q.push_back(e);
               in_ctrl = co;
            end
         end
         if (end_stop) fd_pend++;
      end
      bus_start();
      for (int i = 0; i < nb; i++) begin
         put_byte(frm[i], matched);
         if (i == 0 && matched) chk("busy_after_addr", 32'(busy), 32'd1);
      end
      for (int i = 0; i < part; i++) put_bit(1'($urandom % 2), 1'b0);
      if (end_stop) begin
         bus_stop();
         bus_idle = 1'b1;
         cyc_wait(4);
         chk("busy_after_stop", 32'(busy), 32'd0);
         chk("byte_cnt_after_stop", 32'(byte_cnt), 32'(exp_cnt));
         chk("frame_done_seen", 32'(fd_pend), 32'd0);
      end else begin
         bus_idle = 1'b0;
      end
      chk("strobes_all_seen", 32'(exp_q.size()), 32'd0);
      chk("frame_start_seen", 32'(fs_pend), 32'd0);
   endtask

   initial begin
      #(90000 * 40);
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int nb, part, r;
      bit stp;
      ctrl_tab[0] = CTRL_CMD_STREAM;
      ctrl_tab[1] = CTRL_DATA_STREAM;
      ctrl_tab[2] = CTRL_CMD_SINGLE;
      ctrl_tab[3] = CTRL_DATA_SINGLE;

      // Reset state
      cyc_wait(5);
      chk("reset_outputs", 32'({rx_byte, rx_valid, rx_dc, frame_start, frame_done, busy, byte_cnt}), 32'd0);
      chk("reset_sda_released", 32'(sda_bus), 32'd1);
      rst_n = 1'b1;
      cyc_wait(5);

      // Command stream at ~100 kHz
      q = 62;
      obs_q.delete();
      frm[0] = 8'h78; frm[1] = 8'h00; frm[2] = 8'hAE; frm[3] = 8'hA8; frm[4] = 8'h1F;
      run_frame(5, 0, 1'b1);
      chk("t1_count", 32'(obs_q.size()), 32'd3);
      if (obs_q.size() == 3) begin
         chk("t1_b0", 32'(obs_q[0]), 32'h0AE);
         chk("t1_b1", 32'(obs_q[1]), 32'h0A8);
         chk("t1_b2", 32'(obs_q[2]), 32'h01F);
      end
      chk("t1_byte_cnt", 32'(byte_cnt), 32'd3);

      // Data stream
      q = 10;
      obs_q.delete();
      frm[0] = 8'h78; frm[1] = 8'h40; frm[2] = 8'hFF; frm[3] = 8'h00; frm[4] = 8'h55;
      run_frame(5, 0, 1'b1);
      chk("t2_count", 32'(obs_q.size()), 32'd3);
      if (obs_q.size() == 3) begin
         chk("t2_b0", 32'(obs_q[0]), 32'h1FF);
         chk("t2_b1", 32'(obs_q[1]), 32'h100);
         chk("t2_b2", 32'(obs_q[2]), 32'h155);
      end

      // Single-byte control mode alternates control and payload
      obs_q.delete();
      frm[0] = 8'h78; frm[1] = 8'h80; frm[2] = 8'hAF; frm[3] = 8'hC0; frm[4] = 8'h12;
      run_frame(5, 0, 1'b1);
      chk("t3_count", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() == 2) begin
         chk("t3_b0", 32'(obs_q[0]), 32'h0AF);
         chk("t3_b1", 32'(obs_q[1]), 32'h112);
      end
      chk("t3_byte_cnt", 32'(byte_cnt), 32'd2);

      // Foreign address and read request must be left alone
      quiet_win = 1'b1;
      frm[0] = 8'h7A;
      run_frame(1, 0, 1'b1);
      frm[0] = 8'h79;
      run_frame(1, 0, 1'b1);
      cyc_wait(2);
      quiet_win = 1'b0;
      chk("mismatch_no_drive", 32'(drive_viol), 32'd0);
      chk("mismatch_no_busy", 32'(busy_viol), 32'd0);

      // Partial byte cut by STOP, then by repeated START
      frm[0] = 8'h78; frm[1] = 8'h00;
      run_frame(2, 4, 1'b1);
      frm[0] = 8'h78; frm[1] = 8'h40;
      run_frame(2, 4, 1'b0);
      frm[0] = 8'h78; frm[1] = 8'h40; frm[2] = 8'h5A;
      run_frame(3, 0, 1'b1);
      chk("partial_byte_cnt", 32'(byte_cnt), 32'd1);

      // Reset while the target holds SDA low for the address ACK
      fs_pend++;
      exp_cnt = 0;
      m_low = 1'b1;
      cyc_wait(q);
      scl = 1'b0;
      cyc_wait(q);
      for (int i = 7; i >= 0; i--) put_bit(frm[0][i], 1'b0);
      m_low = 1'b0;
      cyc_wait(q);
      chk("ack_driven_before_reset", 32'(sda_bus), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_ack_sda", 32'(sda_bus), 32'd1);
      chk("reset_mid_ack_outputs", 32'({rx_byte, rx_valid, rx_dc, frame_start, frame_done, busy, byte_cnt}), 32'd0);
      cyc_wait(3);
      scl = 1'b1;
      cyc_wait(q);
      rst_n = 1'b1;
      cyc_wait(5);
      bus_idle = 1'b1;
      chk("fs_consumed_before_reset", 32'(fs_pend), 32'd0);
      frm[0] = 8'h78; frm[1] = 8'h00; frm[2] = 8'hAE; frm[3] = 8'hAF;
      run_frame(4, 0, 1'b1);

      // Randomised frames against the model
      for (int f = 0; f < 12; f++) begin
         q = 5 + int'($urandom % 6);
         nb = 1 + int'($urandom % 5);
         r = int'($urandom % 10);
         frm[0] = (r < 7) ? 8'h78 : (r == 7) ? 8'h7A : (r == 8) ? 8'h79 : 8'($urandom);
         frm[1] = ctrl_tab[$urandom % 4];
         for (int i = 2; i < 8; i++) frm[i] = 8'($urandom);
         part = ($urandom % 3 == 0) ? 1 + int'($urandom % 6) : 0;
         stp = (f == 11) || ($urandom % 3 != 0);
         run_frame(nb, part, stp);
      end

      cyc_wait(10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/oled_i2c_rx_slave.md
Name: oled_i2c_rx_slave

Overview:
- I2C write-only target that models the SSD1306 0.91" OLED's I2C interface inside the FPGA.
- Receives the frames produced by the OLED write engine: address, control byte, then command or data bytes.
- Drives ACK/NACK on SDA (open-drain) and presents each decoded payload byte as a one-cycle strobe tagged command/data.
- Used for loopback self-test and for the bench scoreboard. Runs on the same 25 MHz system clock.

Parameters:
SLAVE_ADDR, 7'h3C, 7-bit I2C address this target answers to
SYNC_STAGES, 2, synchroniser depth for OLED_SCL/OLED_SDA (min 2)

Ports:
CLOCK  input  1  system clock, 25 MHz
RST_n  input  1  asynchronous active-low reset
OLED_SCL  input  1  I2C clock from the master
OLED_SDA  inout  1  I2C data; block drives only 1'b0 or 1'bz
rx_byte  output  8  last received payload byte
rx_valid  output  1  one-cycle strobe, rx_byte/rx_dc valid
rx_dc  output  1  0 = command byte, 1 = GDDRAM data byte
frame_start  output  1  one-cycle pulse when the address matches with R/W=0
frame_done  output  1  one-cycle pulse on STOP ending an addressed frame
busy  output  1  high from address match until STOP or repeated START
byte_cnt  output  16  payload bytes accepted in the current frame, saturating

Behaviour:
- Reset (RST_n low, asynchronous):
  - All outputs are 0 and OLED_SDA is released (z).
  - The FSM goes to IDLE and the synchronisers are cleared to 1.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, plus one delay flop for edge detect.
  - All decisions use the synchronised values.
- Bus condition detection:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled MSB first on each synchronised SCL rising edge.
  - SDA changes while SCL is high are never treated as data.
- FSM states: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: shifts 8 bits.
    - {addr,rw} == {SLAVE_ADDR,0} -> ADDR_ACK, and pulse frame_start.
    - Any other value -> IGNORE, with SDA left released (NACK).
  - ADDR_ACK -> CTRL.
  - CTRL: shifts the control byte. Latch Co=bit7 and dc=bit6; bits 5:0 are ignored. Then -> CTRL_ACK.
  - CTRL_ACK -> DATA.
  - DATA: shifts 8 bits.
    - On the 8th rising edge, pulse rx_valid with rx_byte and rx_dc=dc, and increment byte_cnt (saturates at 16'hFFFF).
    - Then -> DATA_ACK.
  - DATA_ACK exit:
    - Co=0 (stream) -> DATA.
    - Co=1 (single) -> CTRL.
  - IGNORE: waits for START or STOP; never drives SDA.
- ACK timing:
  - In each *_ACK state, drive SDA low on the first SCL falling edge after the 8th bit.
  - Release SDA on the next SCL falling edge (the 9th clock's falling edge), then enter the next state.
  - SDA is never driven while SCL is high except within the 9th clock.
- Latency: rx_valid asserts exactly SYNC_STAGES+1 CLOCK cycles after the raw SCL rising edge of the byte's LSB.
- Boundaries:
  - Repeated START in any state: release SDA, drop busy, discard any partial byte, go to ADDR.
  - STOP in any state: release SDA and go to IDLE.
    - If busy was high, pulse frame_done in the same cycle busy falls.
    - A partial byte is discarded and no rx_valid is produced.
  - START/STOP detected on the same cycle as an SCL edge: the bus condition wins, because SCL is high with no edge.
  - byte_cnt clears on frame_start and holds its value after frame_done until the next frame_start.
  - Reset mid-ACK: SDA is released immediately (asynchronous).

Decomposition:
- Shared package oled_i2c_pkg holds:
  - OLED_I2C_ADDR = 7'h3C.
  - Control byte constants CTRL_CMD_STREAM = 8'h00, CTRL_DATA_STREAM = 8'h40, CTRL_CMD_SINGLE = 8'h80, CTRL_DATA_SINGLE = 8'hC0.
  - The FSM state encoding.
- One natural sub-module, i2c_bus_cond_detect: synchronisers plus edge detect, producing scl_rise, scl_fall, start_det and stop_det pulses along with the synchronised sda.

Test Plan:
- Drive a bench master at 100 kHz with 0x78 (addr 3C, W), 0x00, 0xAE, 0xA8, 0x1F, STOP.
  - Required: ACK on all 5 bytes.
  - Required: rx_valid x3 with bytes AE, A8, 1F and rx_dc=0.
  - Required: byte_cnt=3 and one frame_done.
- Send 0x78, 0x40, 0xFF, 0x00, 0x55, STOP.
  - Required: three data strobes FF, 00, 55 with rx_dc=1.
- Send 0x78, 0x80, 0xAF, 0xC0, 0x12, STOP.
  - Required: strobes AF (dc=0) and 12 (dc=1); the 0xC0 byte is decoded as control, not payload.
- Address mismatch 0x7A, then 0x79 (read):
  - Required: SDA never driven low, no frame_start or rx_valid, busy stays 0.
- STOP after 4 bits of a data byte, then repeated START mid-byte in a second frame.
  - Required: no rx_valid for either partial byte.
  - Required: the next 0x78 is ACKed and byte_cnt restarts at 0.
- Assert RST_n low during the ACK low phase.
  - Required: OLED_SDA becomes z in the same cycle and all outputs go to 0.
  - Required: after release, a full frame decodes correctly.
